// File: rtl/ip_result_fifo.sv
// Capture stage for ip_full results: samples {dout_a, dout_b} on each rising edge of ready
// into a first-word-fall-through FIFO. Optional drop counter via IP_RESULT_FIFO_DROP_CNT_EN.
module ip_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [A_W-1:0]             in_a,
    input  logic [B_W-1:0]             in_b,
    input  logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_W-1:0]             out_a,
    output logic [B_W-1:0]             out_b,
    output logic [$clog2(DEPTH):0]     count,
`ifdef IP_RESULT_FIFO_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = A_W + B_W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;

    logic          ready_q, ready_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic capture, push, pop, drop;

    always_comb begin
        capture    = in_ready & ~ready_q;
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        pop        = ~empty & out_ready;
        push       = capture & (~full | pop);
        drop       = capture & full & ~pop;

        ready_d    = in_ready;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

`ifdef IP_RESULT_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = ~empty;
        out_a     = empty ? '0 : head[EW-1:B_W];
        out_b     = empty ? '0 : head[B_W-1:0];
        count     = count_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_ip_result_fifo.sv
// Directed self-checking bench for ip_result_fifo (DEPTH=4); drop_cnt checks are compiled in
// only when IP_RESULT_FIFO_DROP_CNT_EN is defined.
module tb_ip_result_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_a;
    logic [3:0] in_b;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic [3:0] out_b;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef IP_RESULT_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int vectors;
    int miscompares;

    ip_result_fifo #(
        .DEPTH (4),
        .A_W   (8),
        .B_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count),
`ifdef IP_RESULT_FIFO_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge of in_ready carrying (a, b); occupies two cycles.
    task automatic capture(input logic [7:0] a, input logic [3:0] b);
        in_a     = a;
        in_b     = b;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_a);
        chk(tag, {24'd0, out_a}, {24'd0, exp_a});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_a        = 8'h00;
        in_b        = 4'h0;
        in_ready    = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_out_a", {24'd0, out_a}, 32'd0);

        // Single result
        in_a     = 8'hA5;
        in_b     = 4'h3;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_a", {24'd0, out_a}, 32'hA5);
        chk("single_b", {28'd0, out_b}, 32'h3);
        chk("single_count", {29'd0, count}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_empty", {31'd0, empty}, 32'd1);
        chk("single_out_a0", {24'd0, out_a}, 32'd0);
        chk("single_out_b0", {28'd0, out_b}, 32'd0);

        // Level hold: one capture only
        in_a     = 8'h11;
        in_b     = 4'h1;
        in_ready = 1'b1;
        repeat (10) tick();
        in_ready = 1'b0;
        chk("hold_count", {29'd0, count}, 32'd1);
        pop_check("hold_data", 8'h11);
        chk("hold_empty", {31'd0, empty}, 32'd1);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) capture(8'(i), 4'(i));
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_ovf", {31'd0, overflow}, 32'd1);
`ifdef IP_RESULT_FIFO_DROP_CNT_EN
        chk("fill_drop_cnt", {24'd0, drop_cnt}, 32'd1);
`endif
        chk("fill_head_b", {28'd0, out_b}, 32'h1);
        for (int i = 1; i <= 4; i++) pop_check("drain_order", 8'(i));
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) capture(8'h21 + 8'(i), 4'h2);
        chk("pp_full", {31'd0, full}, 32'd1);
        in_a      = 8'h77;
        in_b      = 4'h7;
        in_ready  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_ready  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", {29'd0, count}, 32'd4);
`ifdef IP_RESULT_FIFO_DROP_CNT_EN
        chk("pp_drop_cnt", {24'd0, drop_cnt}, 32'd1);
`endif
        pop_check("pp_order", 8'h22);
        pop_check("pp_order", 8'h23);
        pop_check("pp_order", 8'h24);
        chk("pp_last_b", {28'd0, out_b}, 32'h7);
        pop_check("pp_order", 8'h77);
        chk("pp_empty", {31'd0, empty}, 32'd1);

        // Stall stability
        capture(8'h31, 4'hC);
        chk("stall_a0", {24'd0, out_a}, 32'h31);
        tick();
        capture(8'h32, 4'hD);
        tick();
        chk("stall_a", {24'd0, out_a}, 32'h31);
        chk("stall_b", {28'd0, out_b}, 32'hC);
        chk("stall_count", {29'd0, count}, 32'd2);
        pop_check("stall_drain", 8'h31);
        pop_check("stall_drain", 8'h32);

        // Mid-operation reset with a concurrent capture
        for (int i = 0; i < 3; i++) capture(8'h40 + 8'(i), 4'h4);
        chk("mr_pre_count", {29'd0, count}, 32'd3);
        chk("mr_pre_ovf", {31'd0, overflow}, 32'd1);
        rst      = 1'b1;
        in_a     = 8'h99;
        in_ready = 1'b1;
        tick();
        rst      = 1'b0;
        in_ready = 1'b0;
        chk("mr_count", {29'd0, count}, 32'd0);
        chk("mr_ovf", {31'd0, overflow}, 32'd0);
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
`ifdef IP_RESULT_FIFO_DROP_CNT_EN
        chk("mr_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
        tick();
        chk("mr_count2", {29'd0, count}, 32'd0);

        // in_ready high in the first cycle after reset counts as a capture
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_a     = 8'h5A;
        in_b     = 4'h9;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("post_rst_count", {29'd0, count}, 32'd1);
        chk("post_rst_a", {24'd0, out_a}, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ip_result_fifo.md
# ip_result_fifo

Downstream capture stage for the `ip_full` result interface. It samples the `dout_a`/`dout_b` pair on each rising edge of `ready` and buffers the pairs in a small first-word-fall-through FIFO. It presents them to the next consumer through a valid/ready handshake. It sits between the `ip_full` instance and any slower sink, so results are not lost when the sink stalls.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥ 2.
- `A_W`, 8, width of result A (matches `dout_a`).
- `B_W`, 4, width of result B (matches `dout_b`).

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_a` input A_W: result A from `ip_full` `dout_a`.
- `in_b` input B_W: result B from `ip_full` `dout_b`.
- `in_ready` input 1: `ip_full` `ready` level; a 0→1 transition marks a new result.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts the head entry.
- `out_a` output A_W: head entry, A field.
- `out_b` output B_W: head entry, B field.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `overflow` output 1: sticky flag, set when a result was dropped.

## Operation
- Edge detect:
  - `ready_q` registers `in_ready`; `ready_q` resets to 0.
  - `capture = in_ready & ~ready_q`.
  - If `in_ready` is high in the first cycle after reset, that cycle counts as a capture.
- Push:
  - Condition: `capture & (~full | pop)`.
  - Writes `{in_a, in_b}` at the write pointer, which then increments modulo DEPTH.
- Pop:
  - Condition: `out_valid & out_ready`.
  - The read pointer increments modulo DEPTH.
- Count:
  - +1 on push only, −1 on pop only.
  - Unchanged on push and pop together, including when full.
- Drop:
  - Condition: `capture & full & ~pop`.
  - The pair is discarded, pointers and count are unchanged, and `overflow` is set.
  - `overflow` clears only on `rst`.
- Outputs:
  - `out_valid = ~empty`.
  - `out_a`/`out_b` show the entry at the read pointer while `out_valid=1`, and are forced to 0 while empty.
- No bypass path: a pop requires a stored entry, so an empty FIFO cannot push and pop in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from `count`, not from pointer equality.
- A capture and a pop occurring together in the same cycle while empty is impossible by construction.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge):
  - `count`, `out_valid`, `out_a`, `out_b`, `full`, `overflow` = 0; `empty` = 1.
  - Pointers and `ready_q` = 0.
  - Storage contents are don't-care.
- `rst` asserted mid-operation discards all stored entries at that edge; a capture in the same cycle is ignored.
- Latency: a capture sampled at edge N gives `out_valid`=1 with the data at the head after edge N. A capture into an empty FIFO is visible one cycle later.
- Throughput: one push and one pop per cycle; a `capture` occurs at most every 2 cycles due to edge detection.
- `out_a`/`out_b` stay stable while `out_valid=1 & out_ready=0`.
- `full`, `empty` and `count` are all registered-state derived; no combinational path from `in_*` to outputs.
- `out_valid` does not depend on `out_ready` (no combinational loop).

## Configuration
- `IP_RESULT_FIFO_DROP_CNT_EN`, when defined:
  - Adds output `drop_cnt` [7:0], reset 0.
  - `drop_cnt` increments on every drop and saturates at 255.
  - It clears only on `rst`.
- When undefined: the port and counter are absent; all other behaviour is identical, and `overflow` remains.

## Test plan
- Reset then single result: `in_a`=0xA5, `in_b`=0x3, `in_ready` rises at cycle 2 → `out_valid`=1 from cycle 3 with `out_a`=0xA5, `out_b`=0x3, `count`=1. Pop with `out_ready`=1 → `empty`=1, `out_a`=0.
- Level hold: `in_ready` held high for 10 cycles → exactly one entry captured (`count`=1).
- Fill and overflow, DEPTH=4, `out_ready`=0: five rising edges carrying A=0x01..0x05 → `full`=1, `count`=4, `overflow`=1, `drop_cnt`=1 if enabled. Draining yields 0x01..0x04 in order and 0x05 is absent.
- Full with simultaneous push/pop: full FIFO, `out_ready`=1 in the capture cycle of A=0x77 → no drop, `count` stays 4, and 0x77 emerges last after the wrapped entries.
- Stall stability: `out_valid`=1, `out_ready`=0 for 5 cycles while a new capture arrives → `out_a`/`out_b` unchanged and `count` increments by 1.
- Mid-operation reset: `count`=3 and `overflow`=1, assert `rst` for one cycle together with a capture → next cycle `count`=0, `overflow`=0, `out_valid`=0, and no entry stored.
